fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_ctrl.sv | 140 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit:
// sequencer state, fetch queue entry layout and instruction geometry.
package fetch_pkg;

    localparam int INSTR_W     = 32;
    localparam int INSTR_BYTES = 4;
    localparam int PC_W        = 64;

    typedef enum logic [1:0] {
        RUN,
        FULL,
        FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch queue: synchronous FIFO of fetch_entry_t, DEPTH entries (power of two).
// Ports: clk, reset (sync, active-high); push/pop/flush controls, din entry in;
// full/empty status and head entry out. Flush outranks push and pop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic         full,
    output logic         empty,
    output fetch_entry_t head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [CW-1:0]  count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; the head is only meaningful when non-empty.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads the word-aligned ROM,
// queues {pc, instr} entries and hands them to decode over valid/ready.
// Ports: clk, reset (sync, active-high); imem_addr/imem_instr ROM side;
// redirect_valid/redirect_pc from branch resolution; out_valid/out_ready/
// out_instr/out_pc to decode; fault on illegal fetch address;
// perf_fetched/perf_stalls counters, live only when FETCH_PERF_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter int                MEM_SIZE = 1024,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [31:0]        imem_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    output logic               fault,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stalls
);

    fetch_state_t      state;
    fetch_state_t      state_next;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W:0]   pc_last;
    logic              illegal;
    logic              push;
    logic              pop;
    logic              flush;
    logic              q_full;
    logic              q_empty;
    fetch_entry_t      wr_entry;
    fetch_entry_t      head;

    // One extra bit so a PC near the top of the space cannot wrap to legal.
    assign pc_last = {1'b0, pc} + (ADDR_W+1)'(INSTR_BYTES - 1);
    assign illegal = (pc[1:0] != 2'b00) ||
                     (pc_last >= (ADDR_W+1)'(MEM_SIZE));
    assign pop     = !q_empty && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_next;
            pc    <= pc_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush      = 1'b1;
            pc_next    = redirect_pc;
            state_next = RUN;
        end else begin
            unique case (state)
                RUN: begin
                    if (illegal) begin
                        state_next = FAULT;
                    end else if (!q_full || pop) begin
                        push    = 1'b1;
                        pc_next = pc + ADDR_W'(INSTR_BYTES);
                    end else begin
                        state_next = FULL;
                    end
                end
                FULL: begin
                    // PC was legal on entry and has been held since.
                    if (pop) begin
                        push       = 1'b1;
                        pc_next    = pc + ADDR_W'(INSTR_BYTES);
                        state_next = RUN;
                    end
                end
                FAULT: ;
                default: ;
            endcase
        end
    end

    assign wr_entry.pc    = PC_W'(pc);
    assign wr_entry.instr = imem_instr;

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_entry),
        .full  (q_full),
        .empty (q_empty),
        .head  (head)
    );

    assign imem_addr = pc;
    assign fault     = (state == FAULT);
    assign out_valid = !q_empty;
    // Masked so the head reads as zero out of reset and while empty.
    assign out_instr = q_empty ? '0 : head.instr;
    assign out_pc    = q_empty ? '0 : ADDR_W'(head.pc);

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q;
    logic [31:0] stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            stalls_q  <= '0;
        end else begin
            if (push)          fetched_q <= fetched_q + 32'd1;
            if (state == FULL) stalls_q  <= stalls_q + 32'd1;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stalls  = stalls_q;
`else
    assign perf_fetched = '0;
    assign perf_stalls  = '0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus a randomized
// phase, all compared each cycle against a queue-based behavioural model.
module tb_fetch_ctrl;

    localparam int          MEM_SIZE = 1024;
    localparam int          QDEPTH   = 2;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fault;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stalls;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fault          (fault),
        .perf_fetched   (perf_fetched),
        .perf_stalls    (perf_stalls)
    );

    function automatic logic [31:0] rom(input logic [63:0] a);
        if (a < 64'(MEM_SIZE)) return 32'(a >> 2);
        return 32'hDEAD_BEEF;
    endfunction

    always_comb imem_instr = rom(imem_addr);

    function automatic bit legal(input logic [63:0] a);
        logic [64:0] last;
        last = {1'b0, a} + 65'd3;
        return (a[1:0] == 2'b00) && (last < 65'(MEM_SIZE));
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t",
                     name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of {pc, instr}, a PC, and a sticky
    // fault flag. A fetch happens when the PC is legal, nothing is
    // redirecting, no fault is pending, and a slot is or becomes free.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [63:0] m_pc = '0;
    bit          m_fault = 0;
    bit          m_in_full = 0;
    bit          started = 0;
    int unsigned m_fetched = 0;
    int unsigned m_stalls = 0;

    always @(posedge clk) begin
        bit pop_m, ok, push_m, nfull;
        if (reset) begin
            q.delete();
            m_pc      = RESET_PC;
            m_fault   = 0;
            m_in_full = 0;
            m_fetched = 0;
            m_stalls  = 0;
            started   = 1;
        end else if (started) begin
            pop_m  = (q.size() > 0) && out_ready;
            ok     = !redirect_valid && !m_fault && legal(m_pc);
            push_m = ok && ((q.size() < QDEPTH) || pop_m);
            nfull  = ok && (q.size() == QDEPTH) && !pop_m;
            if (m_in_full) m_stalls++;
            if (pop_m) void'(q.pop_front());
            if (redirect_valid) begin
                q.delete();
                m_pc    = redirect_pc;
                m_fault = 0;
            end else if (push_m) begin
                q.push_back('{m_pc, rom(m_pc)});
                m_pc += 64'd4;
                m_fetched++;
            end else if (!m_fault && !legal(m_pc)) begin
                m_fault = 1;
            end
            m_in_full = nfull;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("fault", 64'(fault), 64'(m_fault));
            chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("out_pc", out_pc, q[0].pc);
                chk("out_instr", 64'(out_instr), 64'(q[0].instr));
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", 64'(perf_fetched), 64'(m_fetched));
            chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
`else
            chk("perf_fetched", 64'(perf_fetched), 64'd0);
            chk("perf_stalls", 64'(perf_stalls), 64'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic redirect(input logic [63:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        chk("rst_imem_addr", imem_addr, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_instr", 64'(out_instr), 64'd0);

        // Sequential fetch
        reset = 1'b0;
        out_ready = 1'b1;
        chk("seq_first_empty", 64'(out_valid), 64'd0);
        tick();
        chk("seq_valid0", 64'(out_valid), 64'd1);
        chk("seq_pc0", out_pc, 64'h0);
        tick();
        chk("seq_pc1", out_pc, 64'h4);
        chk("seq_instr1", 64'(out_instr), 64'd1);
        repeat (6) tick();
        chk("seq_pc7", out_pc, 64'h1c);

        // Backpressure
        out_ready = 1'b0;
        do_reset();
        repeat (5) tick();
        chk("bp_addr_held", imem_addr, 64'h8);
        chk("bp_head", out_pc, 64'h0);
        out_ready = 1'b1;
        tick();
        chk("bp_pc4", out_pc, 64'h4);
`ifdef FETCH_PERF_EN
        chk("bp_stalls", 64'(perf_stalls), 64'd3);
`endif
        tick();
        chk("bp_pc8", out_pc, 64'h8);

        // Redirect with two entries queued
        out_ready = 1'b0;
        do_reset();
        repeat (2) tick();
        redirect(64'h40);
        out_ready = 1'b1;
        chk("rd_flushed", 64'(out_valid), 64'd0);
        chk("rd_addr", imem_addr, 64'h40);
        tick();
        chk("rd_valid", 64'(out_valid), 64'd1);
        chk("rd_pc", out_pc, 64'h40);

        // Bounds fault, drain, recovery
        redirect(64'd1000);
        repeat (12) tick();
        chk("bf_fault", 64'(fault), 64'd1);
        chk("bf_drained", 64'(out_valid), 64'd0);
        chk("bf_addr", imem_addr, 64'd1024);
        redirect(64'h0);
        chk("bf_cleared", 64'(fault), 64'd0);
        tick();
        chk("bf_resume", out_pc, 64'h0);

        // Misaligned redirect
        redirect(64'h6);
        chk("mis_no_fault_yet", 64'(fault), 64'd0);
        tick();
        chk("mis_fault", 64'(fault), 64'd1);
        chk("mis_empty", 64'(out_valid), 64'd0);

        // Reset beats redirect mid-stream
        redirect(64'h10);
        repeat (4) tick();
        reset = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h80;
        tick();
        reset = 1'b0;
        redirect_valid = 1'b0;
        chk("mr_addr", imem_addr, RESET_PC);
        chk("mr_empty", 64'(out_valid), 64'd0);
        chk("mr_fault", 64'(fault), 64'd0);
        chk("mr_fetched", 64'(perf_fetched), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            out_ready = ($urandom_range(9) < 7);
            reset = ($urandom_range(199) == 0);
            redirect_valid = ($urandom_range(29) == 0);
            case ($urandom_range(4))
                0, 1: redirect_pc = 64'($urandom_range(MEM_SIZE/4 - 1)) << 2;
                2: redirect_pc = 64'(MEM_SIZE - 8);
                3: redirect_pc = 64'($urandom_range(MEM_SIZE - 1)) | 64'd1;
                default: redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            endcase
            tick();
        end

        reset = 1'b0;
        redirect_valid = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
